// File: rtl/data_intc_s2m_force_robin_pkg.sv
// Shared helpers for the forced round-robin split/merge pair.
// Both ends call the same functions, so they step through branches in
// the same sequence and ordering survives without tags.
package data_intc_robin_pkg;

    // Occupancy of the 2-entry skid buffer.
    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_ONE   = 2'd1,
        SKID_FULL  = 2'd2
    } skid_state_e;

    // Width of a branch index; a single branch still needs one bit.
    function automatic int robin_iw(input int num);
        return (num > 1) ? $clog2(num) : 1;
    endfunction

    // Next branch in the forced order, wrapping at num-1 (works for any num).
    function automatic int robin_next(input int idx, input int num);
        return (idx == num - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/data_intc_s2m_force_robin_if.sv
// Valid/ready stream bundle. W is the number of valid/ready lanes sharing
// one data bus (1 for a plain stream, NUM for the broadcast branch side).
interface data_intc_s2m_force_robin_if #(
    parameter int W     = 1,
    parameter int DSIZE = 32
);
    logic [W-1:0]     valid;
    logic [DSIZE-1:0] data;
    logic [W-1:0]     ready;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/data_intc_s2m_force_robin_skid2.sv
// Two-entry skid buffer with a registered input ready.
// in_ready is computed from the next occupancy, so it can never accept a
// third beat. The head register keeps its last value when the buffer
// drains, so out_data stays put while empty.
module data_c_skid2
    import data_intc_robin_pkg::*;
#(
    parameter int DSIZE = 32
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [DSIZE-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [DSIZE-1:0] out_data,
    input  logic             out_ready
);

    skid_state_e      state_reg, state_next;
    logic [DSIZE-1:0] head_reg, head_next;
    logic [DSIZE-1:0] tail_reg, tail_next;
    logic             in_ready_reg, in_ready_next;
    logic             push, pop;

    assign push      = in_valid & in_ready_reg;
    assign pop       = (state_reg != SKID_EMPTY) & out_ready;
    assign in_ready  = in_ready_reg;
    assign out_valid = (state_reg != SKID_EMPTY);
    assign out_data  = head_reg;

    // Occupancy transitions and entry moves for push/pop combinations.
    always_comb begin
        state_next = state_reg;
        head_next  = head_reg;
        tail_next  = tail_reg;
        case (state_reg)
            SKID_EMPTY: begin
                if (push) begin
                    head_next  = in_data;
                    state_next = SKID_ONE;
                end
            end
            SKID_ONE: begin
                if (push && pop) begin
                    head_next = in_data;
                end else if (push) begin
                    tail_next  = in_data;
                    state_next = SKID_FULL;
                end else if (pop) begin
                    state_next = SKID_EMPTY;
                end
            end
            SKID_FULL: begin
                // in_ready is low here, so only a pop can happen.
                if (pop) begin
                    head_next  = tail_reg;
                    state_next = SKID_ONE;
                end
            end
            default: state_next = SKID_EMPTY;
        endcase
        in_ready_next = (state_next != SKID_FULL);
    end

    // State, storage and registered ready; reset drops any buffered beats.
    always_ff @(posedge clock) begin
        if (!rst_n) begin
            state_reg    <= SKID_EMPTY;
            head_reg     <= '0;
            tail_reg     <= '0;
            in_ready_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            head_reg     <= head_next;
            tail_reg     <= tail_next;
            in_ready_reg <= in_ready_next;
        end
    end

endmodule

// File: rtl/data_intc_s2m_force_robin.sv
// Forced round-robin splitter: beat k of the upstream stream goes to
// branch k mod NUM, and the splitter waits on the current branch even if
// others are ready. Data is broadcast; only the selected valid is raised.
module data_intc_s2m_force_robin
    import data_intc_robin_pkg::*;
#(
    parameter int NUM   = 8,
    parameter int DSIZE = 32,
    localparam int IW   = robin_iw(NUM)
) (
    input  logic                            clock,
    input  logic                            rst_n,
    data_intc_s2m_force_robin_if.slave      s00,
    data_intc_s2m_force_robin_if.master     m00,
    output logic [IW-1:0]                   robin_index
);

    logic             buf_valid;
    logic [DSIZE-1:0] buf_data;
    logic             buf_in_ready;
    logic             sel_ready;
    logic             transfer;
    logic [NUM-1:0]   sel_onehot;
    logic [NUM-1:0]   valid_vec;
    logic [IW-1:0]    robin_index_reg, robin_index_next;

    data_c_skid2 #(
        .DSIZE (DSIZE)
    ) u_skid (
        .clock     (clock),
        .rst_n     (rst_n),
        .in_valid  (s00.valid[0]),
        .in_data   (s00.data),
        .in_ready  (buf_in_ready),
        .out_valid (buf_valid),
        .out_data  (buf_data),
        .out_ready (sel_ready)
    );

    assign s00.ready = buf_in_ready;

    // One-hot decode of the served branch; valid only goes to that branch.
    for (genvar gi = 0; gi < NUM; gi++) begin : g_branch
        assign sel_onehot[gi] = (robin_index_reg == IW'(gi));
        assign valid_vec[gi]  = buf_valid & sel_onehot[gi];
    end

    // Ready from non-selected branches is masked off here.
    assign sel_ready   = |(m00.ready & sel_onehot);
    assign transfer    = buf_valid & sel_ready;
    assign m00.valid   = valid_vec;
    assign m00.data    = buf_data;
    assign robin_index = robin_index_reg;

    // Index moves on a completed transfer only, never on idle or stall.
    always_comb begin
        robin_index_next = robin_index_reg;
        if (transfer) begin
            robin_index_next = IW'(robin_next(int'(robin_index_reg), NUM));
        end
    end

    // Served-branch register.
    always_ff @(posedge clock) begin
        if (!rst_n) begin
            robin_index_reg <= '0;
        end else begin
            robin_index_reg <= robin_index_next;
        end
    end

endmodule

// File: tb/tb_data_intc_s2m_force_robin.sv
// Bench for the forced round-robin splitter: four instances (NUM=8,4,3,5)
// covering reset, streaming, forced wait, non-power-of-two wrap, random
// backpressure against a queue model, and reset in mid-stream.
module tb_data_intc_s2m_force_robin;

    logic clock = 1'b0;
    logic rst_n = 1'b0;
    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_err = 0;

    data_intc_s2m_force_robin_if #(.W(1), .DSIZE(32)) s8 ();
    data_intc_s2m_force_robin_if #(.W(8), .DSIZE(32)) m8 ();
    data_intc_s2m_force_robin_if #(.W(1), .DSIZE(32)) s4 ();
    data_intc_s2m_force_robin_if #(.W(4), .DSIZE(32)) m4 ();
    data_intc_s2m_force_robin_if #(.W(1), .DSIZE(32)) s3 ();
    data_intc_s2m_force_robin_if #(.W(3), .DSIZE(32)) m3 ();
    data_intc_s2m_force_robin_if #(.W(1), .DSIZE(32)) s5 ();
    data_intc_s2m_force_robin_if #(.W(5), .DSIZE(32)) m5 ();

    logic [2:0] idx8;
    logic [1:0] idx4;
    logic [1:0] idx3;
    logic [2:0] idx5;

    data_intc_s2m_force_robin #(.NUM(8), .DSIZE(32)) u8 (
        .clock(clock), .rst_n(rst_n), .s00(s8), .m00(m8), .robin_index(idx8));
    data_intc_s2m_force_robin #(.NUM(4), .DSIZE(32)) u4 (
        .clock(clock), .rst_n(rst_n), .s00(s4), .m00(m4), .robin_index(idx4));
    data_intc_s2m_force_robin #(.NUM(3), .DSIZE(32)) u3 (
        .clock(clock), .rst_n(rst_n), .s00(s3), .m00(m3), .robin_index(idx3));
    data_intc_s2m_force_robin #(.NUM(5), .DSIZE(32)) u5 (
        .clock(clock), .rst_n(rst_n), .s00(s5), .m00(m5), .robin_index(idx5));

    typedef struct packed {
        logic        s_valid;
        logic [31:0] s_data;
        logic [2:0]  m_ready;
        logic [2:0]  exp_valid;
        logic [31:0] exp_data;
        logic [1:0]  exp_idx;
        logic        exp_ready;
    } vec3_t;

    vec3_t tab [8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Advance one edge; outputs are then sampled 1 time unit later.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] q[$];
        int          delivered;
        int          accepted;
        int          cycles;
        int          n_adv;
        bit          m_rdy;
        bit          acc;
        bit          xfer;
        logic [31:0] push_data;
        logic [4:0]  exp_v5;

        // The NUM=3 sequence: beats 1..7 with every branch ready.
        tab[0] = '{1'b1, 32'd1, 3'b111, 3'b001, 32'd1, 2'd0, 1'b1};
        tab[1] = '{1'b1, 32'd2, 3'b111, 3'b010, 32'd2, 2'd1, 1'b1};
        tab[2] = '{1'b1, 32'd3, 3'b111, 3'b100, 32'd3, 2'd2, 1'b1};
        tab[3] = '{1'b1, 32'd4, 3'b111, 3'b001, 32'd4, 2'd0, 1'b1};
        tab[4] = '{1'b1, 32'd5, 3'b111, 3'b010, 32'd5, 2'd1, 1'b1};
        tab[5] = '{1'b1, 32'd6, 3'b111, 3'b100, 32'd6, 2'd2, 1'b1};
        tab[6] = '{1'b1, 32'd7, 3'b111, 3'b001, 32'd7, 2'd0, 1'b1};
        tab[7] = '{1'b0, 32'd0, 3'b111, 3'b000, 32'd7, 2'd1, 1'b1};

        s8.valid = '0; s8.data = '0; m8.ready = '0;
        s4.valid = '0; s4.data = '0; m4.ready = '0;
        s3.valid = '0; s3.data = '0; m3.ready = '0;
        s5.valid = '0; s5.data = '0; m5.ready = '0;

        // Reset for three edges, then release.
        rst_n = 1'b0;
        tick(); tick(); tick();
        chk("rst_s5_ready", s5.ready, 0);
        chk("rst_m5_valid", m5.valid, 0);
        chk("rst_m5_data", m5.data, 0);
        chk("rst_idx5", idx5, 0);
        chk("rst_s8_ready", s8.ready, 0);
        rst_n = 1'b1;
        tick();
        chk("rel_s5_ready", s5.ready, 1);
        chk("rel_m5_valid", m5.valid, 0);
        chk("rel_idx5", idx5, 0);
        chk("rel_s8_ready", s8.ready, 1);
        $display("reset: s5_ready=%0d idx5=%0d", s5.ready, idx5);

        // NUM=8 streaming, 0x10..0x1F back to back with all branches ready.
        m8.ready = '1;
        for (int r = 0; r < 16; r++) begin
            s8.valid = 1'b1;
            s8.data  = 32'h10 + 32'(r);
            tick();
            chk("s8_valid", m8.valid, 64'(1) << (r % 8));
            chk("s8_data", m8.data, 64'h10 + 64'(r));
            chk("s8_idx", idx8, 64'(r % 8));
            chk("s8_ready", s8.ready, 1);
            $display("stream8 beat %0d: valid=%b data=0x%0h idx=%0d", r, m8.valid, m8.data, idx8);
        end
        s8.valid = 1'b0;
        tick();
        chk("s8_end_valid", m8.valid, 0);
        chk("s8_end_idx", idx8, 0);
        chk("s8_end_data", m8.data, 64'h1F);

        // NUM=3 table.
        for (int i = 0; i < 8; i++) begin
            s3.valid = tab[i].s_valid;
            s3.data  = tab[i].s_data;
            m3.ready = tab[i].m_ready;
            tick();
            chk("t3_valid", m3.valid, tab[i].exp_valid);
            chk("t3_data", m3.data, tab[i].exp_data);
            chk("t3_idx", idx3, tab[i].exp_idx);
            chk("t3_ready", s3.ready, tab[i].exp_ready);
            $display("table3 row %0d: valid=%b data=0x%0h idx=%0d", i, m3.valid, m3.data, idx3);
        end

        // NUM=4 forced wait on branch 0 while the others are ready.
        m4.ready = 4'b1110;
        s4.valid = 1'b1; s4.data = 32'hA0;
        tick();
        chk("f4_v1", m4.valid, 4'b0001);
        chk("f4_d1", m4.data, 32'hA0);
        chk("f4_r1", s4.ready, 1);
        s4.data = 32'hA1;
        tick();
        chk("f4_v2", m4.valid, 4'b0001);
        chk("f4_r2", s4.ready, 0);
        s4.data = 32'hA2;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("f4_hold_v", m4.valid, 4'b0001);
            chk("f4_hold_d", m4.data, 32'hA0);
            chk("f4_hold_idx", idx4, 0);
            chk("f4_hold_r", s4.ready, 0);
        end
        s4.valid = 1'b0;
        m4.ready = 4'b1111;
        tick();
        chk("f4_pop_v", m4.valid, 4'b0010);
        chk("f4_pop_d", m4.data, 32'hA1);
        chk("f4_pop_idx", idx4, 1);
        chk("f4_pop_r", s4.ready, 1);
        tick();
        chk("f4_empty_v", m4.valid, 0);
        chk("f4_empty_d", m4.data, 32'hA1);
        chk("f4_empty_idx", idx4, 2);
        $display("forced4: idx=%0d data=0x%0h", idx4, m4.data);

        // NUM=5 random traffic against a queue model.
        delivered = 0;
        accepted  = 0;
        m_rdy     = 1'b1;
        cycles    = 0;
        while ((accepted < 2000 || q.size() != 0) && cycles < 20000) begin
            exp_v5 = (q.size() != 0) ? (5'b00001 << (delivered % 5)) : 5'b00000;
            chk("rnd_valid", m5.valid, exp_v5);
            if (q.size() != 0) chk("rnd_data", m5.data, q[0]);
            chk("rnd_idx", idx5, 64'(delivered % 5));
            chk("rnd_ready", s5.ready, m_rdy);
            s5.valid  = (accepted < 2000) && ($urandom_range(3) != 0);
            push_data = $urandom;
            s5.data   = push_data;
            m5.ready  = 5'($urandom);
            acc  = s5.valid[0] & m_rdy;
            xfer = (q.size() != 0) && m5.ready[delivered % 5];
            tick();
            if (xfer) begin
                void'(q.pop_front());
                delivered++;
            end
            if (acc) begin
                q.push_back(push_data);
                accepted++;
            end
            m_rdy = (q.size() < 2);
            cycles++;
        end
        chk("rnd_drain", 64'(delivered), 64'(accepted));
        chk("rnd_count", 64'(accepted), 64'd2000);
        $display("random5: accepted=%0d delivered=%0d cycles=%0d", accepted, delivered, cycles);

        // Walk NUM=5 to branch 3, fill the buffer, then reset mid-stream.
        s5.valid = 1'b0;
        m5.ready = '1;
        tick();
        n_adv = (3 - (delivered % 5) + 5) % 5;
        for (int i = 0; i < n_adv; i++) begin
            s5.valid = 1'b1;
            s5.data  = 32'hC0 + 32'(i);
            tick();
        end
        s5.valid = 1'b0;
        tick();
        chk("mr_idx3", idx5, 3);
        m5.ready = '0;
        s5.valid = 1'b1; s5.data = 32'hB0;
        tick();
        s5.data = 32'hB1;
        tick();
        s5.valid = 1'b0;
        chk("mr_full_v", m5.valid, 5'b01000);
        chk("mr_full_d", m5.data, 32'hB0);
        chk("mr_full_r", s5.ready, 0);
        rst_n = 1'b0;
        tick();
        chk("mr_rst_v", m5.valid, 0);
        chk("mr_rst_idx", idx5, 0);
        chk("mr_rst_r", s5.ready, 0);
        rst_n = 1'b1;
        m5.ready = '1;
        tick();
        chk("mr_rel_r", s5.ready, 1);
        chk("mr_rel_v", m5.valid, 0);
        s5.valid = 1'b1; s5.data = 32'h55;
        tick();
        s5.valid = 1'b0;
        chk("mr_resume_v", m5.valid, 5'b00001);
        chk("mr_resume_d", m5.data, 32'h55);
        chk("mr_resume_idx", idx5, 0);
        tick();
        chk("mr_after_v", m5.valid, 0);
        chk("mr_after_idx", idx5, 1);
        $display("midreset5: idx=%0d", idx5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
